// File: rtl/vx_banked_operand_collector.sv
// Banked GPR operand collector: gathers NUM_SRC operands per request from an owned banked register
// file, serialising bank conflicts internally. Optional conflict-cycle counter under OPC_PERF_EN.
module vx_banked_operand_collector #(
    parameter int NUM_SRC     = 3,
    parameter int NUM_BANKS   = 4,
    parameter int NUM_REGS    = 32,
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int XLEN        = 32,
    parameter int META_W      = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 in_valid,
    output logic                                 in_ready,
    input  logic [$clog2(NUM_WARPS)-1:0]         in_wid,
    input  logic [NUM_SRC*$clog2(NUM_REGS)-1:0]  in_rs,
    input  logic [META_W-1:0]                    in_meta,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [META_W-1:0]                    out_meta,
    output logic [NUM_SRC*NUM_THREADS*XLEN-1:0]  out_data,
    input  logic                                 wb_valid,
    input  logic [$clog2(NUM_WARPS)-1:0]         wb_wid,
    input  logic [$clog2(NUM_REGS)-1:0]          wb_rd,
    input  logic [NUM_THREADS-1:0]               wb_tmask,
    input  logic [NUM_THREADS*XLEN-1:0]          wb_data
`ifdef OPC_PERF_EN
    ,
    output logic [43:0]                          perf_conflict_cycles
`endif
);

    localparam int WID_W  = $clog2(NUM_WARPS);
    localparam int RID_W  = $clog2(NUM_REGS);
    localparam int BANK_W = $clog2(NUM_BANKS);
    localparam int HI_W   = RID_W - BANK_W;
    localparam int ROW_W  = HI_W + WID_W;
    localparam int ROWS   = (NUM_REGS / NUM_BANKS) * NUM_WARPS;
    localparam int SLOT_W = NUM_THREADS * XLEN;
    localparam int IDX_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LAST  = 2'd2,
        OUT   = 2'd3
    } state_t;

    state_t                       state_r, state_s;
    logic [WID_W-1:0]             wid_r;
    logic [NUM_SRC*RID_W-1:0]     rs_r;
    logic [NUM_SRC-1:0]           pending_r;
    logic                         out_valid_r;
    logic [META_W-1:0]            meta_r;
    logic [NUM_SRC*SLOT_W-1:0]    data_r;
    logic [NUM_BANKS-1:0]         route_vld_r;
    logic [IDX_W-1:0]             route_idx_r [NUM_BANKS];

    logic                         in_fire_s;
    logic                         fetch_en_s;
    logic [NUM_SRC-1:0]           init_pend_s;
    logic [NUM_SRC-1:0]           issue_mask_s;
    logic [NUM_SRC-1:0]           pend_left_s;
    logic [NUM_BANKS-1:0]         rd_en_s;
    logic [ROW_W-1:0]             rd_row_s    [NUM_BANKS];
    logic [IDX_W-1:0]             sel_idx_s   [NUM_BANKS];
    logic [SLOT_W-1:0]            rd_data_s   [NUM_BANKS];
    logic                         wb_en_s;
    logic [BANK_W-1:0]            wb_bank_s;
    logic [ROW_W-1:0]             wb_row_s;

    assign in_fire_s = in_valid && in_ready;
    assign out_valid = out_valid_r;
    assign out_meta  = meta_r;
    assign out_data  = data_r;
    assign wb_en_s   = wb_valid && (wb_rd != {RID_W{1'b0}});
    assign wb_bank_s = wb_rd[BANK_W-1:0];
    assign wb_row_s  = {wb_rd[RID_W-1:BANK_W], wb_wid};

    // r0 operands are never fetched; their slot stays at the cleared zero value
    always_comb begin
        init_pend_s = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            init_pend_s[i] = (in_rs[i*RID_W +: RID_W] != {RID_W{1'b0}});
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (in_fire_s) begin
                    state_s = (init_pend_s != '0) ? FETCH : LAST;
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                if (pend_left_s != '0) begin
                    state_s = FETCH;
                end else begin
                    state_s = LAST;
                end
            end
            LAST: state_s = OUT;
            OUT: begin
                if (!out_ready) begin
                    state_s = OUT;
                end else if (in_fire_s) begin
                    state_s = (init_pend_s != '0) ? FETCH : LAST;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // FSM outputs; ready is held low while reset is asserted
    always_comb begin
        in_ready   = 1'b0;
        fetch_en_s = 1'b0;
        case (state_r)
            IDLE:    in_ready   = !reset;
            FETCH:   fetch_en_s = 1'b1;
            LAST:    in_ready   = 1'b0;
            OUT:     in_ready   = out_ready && !reset;
            default: in_ready   = 1'b0;
        endcase
    end

    // Per-bank arbitration: lowest-index pending operand mapped to each bank wins this cycle
    always_comb begin
        issue_mask_s = '0;
        rd_en_s      = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            rd_row_s[b]  = '0;
            sel_idx_s[b] = '0;
        end
        for (int b = 0; b < NUM_BANKS; b++) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (fetch_en_s && pending_r[i] && !rd_en_s[b] &&
                    (rs_r[i*RID_W +: BANK_W] == BANK_W'(b))) begin
                    rd_en_s[b]      = 1'b1;
                    rd_row_s[b]     = {rs_r[i*RID_W+BANK_W +: HI_W], wid_r};
                    sel_idx_s[b]    = IDX_W'(i);
                    issue_mask_s[i] = 1'b1;
                end else begin
                    issue_mask_s[i] = issue_mask_s[i];
                end
            end
        end
        pend_left_s = pending_r & ~issue_mask_s;
    end

    // Request latch, pending tracking, read-return routing and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wid_r       <= '0;
            rs_r        <= '0;
            pending_r   <= '0;
            out_valid_r <= 1'b0;
            meta_r      <= '0;
            data_r      <= '0;
            route_vld_r <= '0;
            for (int b = 0; b < NUM_BANKS; b++) begin
                route_idx_r[b] <= '0;
            end
        end else begin
            out_valid_r <= (state_s == OUT);
            route_vld_r <= rd_en_s;
            for (int b = 0; b < NUM_BANKS; b++) begin
                route_idx_r[b] <= sel_idx_s[b];
            end
            if (in_fire_s) begin
                wid_r     <= in_wid;
                rs_r      <= in_rs;
                meta_r    <= in_meta;
                pending_r <= init_pend_s;
                data_r    <= '0;
            end else begin
                if (fetch_en_s) begin
                    pending_r <= pend_left_s;
                end
                for (int b = 0; b < NUM_BANKS; b++) begin
                    for (int i = 0; i < NUM_SRC; i++) begin
                        if (route_vld_r[b] && (route_idx_r[b] == IDX_W'(i))) begin
                            data_r[i*SLOT_W +: SLOT_W] <= rd_data_s[b];
                        end
                    end
                end
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [SLOT_W-1:0] mem_r [ROWS];
        logic [SLOT_W-1:0] rd_q_r;

        // Lane-masked write; the registered read sees the contents from before a same-cycle write
        always_ff @(posedge clk) begin
            if (wb_en_s && (wb_bank_s == BANK_W'(b))) begin
                for (int l = 0; l < NUM_THREADS; l++) begin
                    if (wb_tmask[l]) begin
                        mem_r[wb_row_s][l*XLEN +: XLEN] <= wb_data[l*XLEN +: XLEN];
                    end
                end
            end
            if (rd_en_s[b]) begin
                rd_q_r <= mem_r[rd_row_s[b]];
            end
        end

        assign rd_data_s[b] = rd_q_r;
    end

`ifdef OPC_PERF_EN
    logic [43:0] perf_r;

    // Counts FETCH cycles that leave work behind, i.e. cycles added by bank conflicts
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_r <= 44'd0;
        end else if (fetch_en_s && (pend_left_s != '0) && (perf_r != {44{1'b1}})) begin
            perf_r <= perf_r + 44'd1;
        end
    end

    assign perf_conflict_cycles = perf_r;
`endif

endmodule
